matmul_sequencer: RTL and testbench

- Control FSM for the matrix-multiplication datapath. Computes C = A x B for square n x n matrices held row-major in a shared word-addressed memory.
- Walks the i/j/k loop nest and issues read addresses for A and B. Drives the accumulator register's clear/write controls and issues the C write-back address and strobe.
- Sits between the top-level start/done handshake and the memory + accumulator datapath.

---
 rtl/matmul_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Control sequencer for C = A x B on square n x n row-major matrices.
// Walks the i/j/k loop nest, issues operand reads, drives the accumulator and writes back C.
module matmul_sequencer #(
  parameter int unsigned word_size = 16,
  parameter int unsigned dim_width = 4,
  parameter int unsigned mem_lat   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [dim_width-1:0] n,
  input  logic [word_size-1:0] base_a,
  input  logic [word_size-1:0] base_b,
  input  logic [word_size-1:0] base_c,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [word_size-1:0] a_addr,
  output logic [word_size-1:0] b_addr,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic                 c_wr_en,
  output logic [word_size-1:0] c_addr,
  output logic [dim_width-1:0] i_idx,
  output logic [dim_width-1:0] j_idx,
  output logic [dim_width-1:0] k_idx
);

  localparam int unsigned LAT_W = (mem_lat > 2) ? $clog2(mem_lat) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    MAC   = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [dim_width-1:0] n_q, n_nxt, n_last;
  logic [dim_width-1:0] i_nxt, j_nxt, k_nxt;
  logic [word_size-1:0] ba_q, bb_q, bc_q, ba_nxt, bb_nxt, bc_nxt;
  logic [word_size-1:0] i_off, k_off, i_off_nxt, k_off_nxt;
  logic [LAT_W-1:0]     lat_cnt, lat_nxt;
  logic                 busy_nxt, done_nxt, rd_en_nxt, acc_clr_nxt, acc_en_nxt, c_wr_en_nxt;
  logic [word_size-1:0] a_addr_nxt, b_addr_nxt, c_addr_nxt;

  assign n_last = n_q - dim_width'(1);

  // State, loop indices, row offsets and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      n_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      k_idx   <= '0;
      i_off   <= '0;
      k_off   <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      c_wr_en <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_addr  <= '0;
    end else begin
      state   <= state_nxt;
      n_q     <= n_nxt;
      ba_q    <= ba_nxt;
      bb_q    <= bb_nxt;
      bc_q    <= bc_nxt;
      i_idx   <= i_nxt;
      j_idx   <= j_nxt;
      k_idx   <= k_nxt;
      i_off   <= i_off_nxt;
      k_off   <= k_off_nxt;
      lat_cnt <= lat_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rd_en   <= rd_en_nxt;
      acc_clr <= acc_clr_nxt;
      acc_en  <= acc_en_nxt;
      c_wr_en <= c_wr_en_nxt;
      a_addr  <= a_addr_nxt;
      b_addr  <= b_addr_nxt;
      c_addr  <= c_addr_nxt;
    end
  end

  // Next state and loop bookkeeping; offsets i*n and k*n advance by adding n
  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    ba_nxt    = ba_q;
    bb_nxt    = bb_q;
    bc_nxt    = bc_q;
    i_nxt     = i_idx;
    j_nxt     = j_idx;
    k_nxt     = k_idx;
    i_off_nxt = i_off;
    k_off_nxt = k_off;
    lat_nxt   = lat_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          if (n != '0) begin
            n_nxt     = n;
            ba_nxt    = base_a;
            bb_nxt    = base_b;
            bc_nxt    = base_c;
            i_nxt     = '0;
            j_nxt     = '0;
            k_nxt     = '0;
            i_off_nxt = '0;
            k_off_nxt = '0;
            state_nxt = CLEAR;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      CLEAR: begin
        k_nxt     = '0;
        k_off_nxt = '0;
        state_nxt = READ;
      end
      READ: begin
        if (mem_lat > 1) begin
          lat_nxt   = LAT_W'(mem_lat - 2);
          state_nxt = WAIT;
        end else begin
          state_nxt = MAC;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = MAC;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      MAC: begin
        if (k_idx == n_last) begin
          state_nxt = WRITE;
        end else begin
          k_nxt     = k_idx + dim_width'(1);
          k_off_nxt = k_off + word_size'(n_q);
          state_nxt = READ;
        end
      end
      WRITE: begin
        if (j_idx != n_last) begin
          j_nxt     = j_idx + dim_width'(1);
          state_nxt = CLEAR;
        end else if (i_idx != n_last) begin
          j_nxt     = '0;
          i_nxt     = i_idx + dim_width'(1);
          i_off_nxt = i_off + word_size'(n_q);
          state_nxt = CLEAR;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt    = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt    = (state_nxt == DONE);
    rd_en_nxt   = (state_nxt == READ);
    acc_clr_nxt = (state_nxt == CLEAR);
    acc_en_nxt  = (state_nxt == MAC);
    c_wr_en_nxt = (state_nxt == WRITE);
    a_addr_nxt  = ba_nxt + i_off_nxt + word_size'(k_nxt);
    b_addr_nxt  = bb_nxt + k_off_nxt + word_size'(j_nxt);
    c_addr_nxt  = bc_nxt + i_off_nxt + word_size'(j_nxt);
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: scoreboarded address streams on a mem_lat=1 instance,
// timing checks on a mem_lat=3 instance.
module tb_matmul_sequencer;

  logic        clk;
  logic        rst;
  logic        start1, start3;
  logic [3:0]  n;
  logic [15:0] base_a, base_b, base_c;

  logic        busy1, done1, rd_en1, acc_clr1, acc_en1, c_wr_en1;
  logic [15:0] a_addr1, b_addr1, c_addr1;
  logic [3:0]  i_idx1, j_idx1, k_idx1;
  logic        busy3, done3, rd_en3, acc_clr3, acc_en3, c_wr_en3;
  logic [15:0] a_addr3, b_addr3, c_addr3;
  logic [3:0]  i_idx3, j_idx3, k_idx3;

  int tests;
  int fails;
  logic [31:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  matmul_sequencer #(.word_size(16), .dim_width(4), .mem_lat(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .n(n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .a_addr(a_addr1), .b_addr(b_addr1),
    .acc_clr(acc_clr1), .acc_en(acc_en1), .c_wr_en(c_wr_en1), .c_addr(c_addr1),
    .i_idx(i_idx1), .j_idx(j_idx1), .k_idx(k_idx1)
  );

  matmul_sequencer #(.word_size(16), .dim_width(4), .mem_lat(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .n(n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy3), .done(done3), .rd_en(rd_en3), .a_addr(a_addr3), .b_addr(b_addr3),
    .acc_clr(acc_clr3), .acc_en(acc_en3), .c_wr_en(c_wr_en3), .c_addr(c_addr3),
    .i_idx(i_idx3), .j_idx(j_idx3), .k_idx(k_idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor for the mem_lat=1 instance
  always @(negedge clk) begin
    logic [31:0] er;
    logic [15:0] ew;
    if (rd_en1) begin
      tests++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL rd_addr: unexpected read a=%h b=%h", a_addr1, b_addr1);
      end else begin
        er = exp_rd.pop_front();
        if ({a_addr1, b_addr1} !== er) begin
          fails++;
          $display("FAIL rd_addr: got a=%h b=%h expected a=%h b=%h", a_addr1, b_addr1, er[31:16], er[15:0]);
        end
      end
    end
    if (c_wr_en1) begin
      tests++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL c_addr: unexpected write c=%h", c_addr1);
      end else begin
        ew = exp_wr.pop_front();
        if (c_addr1 !== ew) begin
          fails++;
          $display("FAIL c_addr: got %h expected %h", c_addr1, ew);
        end
      end
    end
    if (rd_en1 | acc_en1 | acc_clr1 | c_wr_en1) begin
      tests++;
      if ((32'(rd_en1) + 32'(acc_en1) + 32'(acc_clr1) + 32'(c_wr_en1)) != 1) begin
        fails++;
        $display("FAIL strobe_excl: rd=%b acc=%b clr=%b wr=%b expected one-hot", rd_en1, acc_en1, acc_clr1, c_wr_en1);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [3:0] nn, input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    logic [15:0] ea, eb, ec;
    for (int i = 0; i < 32'(nn); i++) begin
      for (int j = 0; j < 32'(nn); j++) begin
        for (int k = 0; k < 32'(nn); k++) begin
          ea = ba + 16'(i * 32'(nn) + k);
          eb = bb + 16'(k * 32'(nn) + j);
          exp_rd.push_back({ea, eb});
        end
        ec = bc + 16'(i * 32'(nn) + j);
        exp_wr.push_back(ec);
      end
    end
  endtask

  // Full run on the mem_lat=1 instance: busy length, done pulse, scoreboard drained
  task automatic run1(input string name, input logic [3:0] nn, input logic [15:0] ba,
                      input logic [15:0] bb, input logic [15:0] bc, input int exp_busy);
    int cnt;
    push_run(nn, ba, bb, bc);
    n = nn; base_a = ba; base_b = bb; base_c = bc;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 5000) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt !== exp_busy) begin
      fails++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, cnt, exp_busy);
    end
    tests++;
    if (done1 !== 1'b1) begin
      fails++;
      $display("FAIL %s done_pulse: got %b expected 1", name, done1);
    end
    tick();
    tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done1, busy1);
    end
    tests++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      fails++;
      $display("FAIL %s sb_drain: got rd_left=%0d wr_left=%0d expected 0 0", name, exp_rd.size(), exp_wr.size());
    end
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    n = '0; base_a = '0; base_b = '0; base_c = '0;
    repeat (3) tick();
    tests++;
    if ({busy1, done1, rd_en1, acc_clr1, acc_en1, c_wr_en1} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl1: got %b expected 000000", {busy1, done1, rd_en1, acc_clr1, acc_en1, c_wr_en1});
    end
    tests++;
    if ({a_addr1, b_addr1, c_addr1, i_idx1, j_idx1, k_idx1} !== 60'b0) begin
      fails++;
      $display("FAIL reset_regs1: got a=%h b=%h c=%h i=%0d j=%0d k=%0d expected all 0",
               a_addr1, b_addr1, c_addr1, i_idx1, j_idx1, k_idx1);
    end
    tests++;
    if ({busy3, done3, rd_en3, acc_clr3, acc_en3, c_wr_en3} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl3: got %b expected 000000", {busy3, done3, rd_en3, acc_clr3, acc_en3, c_wr_en3});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run;
    int cnt;
    push_run(4'd2, 16'h0000, 16'h0010, 16'h0020);
    n = 4'd2; base_a = 16'h0000; base_b = 16'h0010; base_c = 16'h0020;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cnt = 0;
    while (!(acc_en1 && j_idx1 == 4'd1 && k_idx1 == 4'd1) && cnt < 200) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt >= 200) begin
      fails++;
      $display("FAIL midrst_reach_mac: got timeout after %0d cycles expected MAC at j=1 k=1", cnt);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({busy1, done1, rd_en1, acc_clr1, acc_en1, c_wr_en1} !== 6'b0) begin
      fails++;
      $display("FAIL midrst_ctrl: got %b expected 000000", {busy1, done1, rd_en1, acc_clr1, acc_en1, c_wr_en1});
    end
    tests++;
    if ({i_idx1, j_idx1, k_idx1} !== 12'b0 || {a_addr1, b_addr1, c_addr1} !== 48'b0) begin
      fails++;
      $display("FAIL midrst_regs: got i=%0d j=%0d k=%0d a=%h b=%h c=%h expected all 0",
               i_idx1, j_idx1, k_idx1, a_addr1, b_addr1, c_addr1);
    end
    rst = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) tick();
    tests++;
    if (busy1 !== 1'b0 || c_wr_en1 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_stays_idle: got busy=%b wr=%b expected 0 0", busy1, c_wr_en1);
    end
  endtask

  task automatic test_n2;
    run1("n2", 4'd2, 16'h0000, 16'h0010, 16'h0020, 24);
  endtask

  task automatic test_n3_lat3;
    int cyc, rds, accs, wrs, last_rd, bad_gap, overlap;
    cyc = 0; rds = 0; accs = 0; wrs = 0; bad_gap = 0; overlap = 0; last_rd = -100;
    n = 4'd3; base_a = 16'h0100; base_b = 16'h0200; base_c = 16'h0300;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    while (busy3 && cyc < 5000) begin
      if ((cyc - last_rd == 1 || cyc - last_rd == 2) && (rd_en3 | acc_en3 | acc_clr3 | c_wr_en3))
        bad_gap++;
      if (rd_en3) begin
        rds++;
        last_rd = cyc;
      end
      if (acc_en3) begin
        accs++;
        if (cyc - last_rd != 3) bad_gap++;
      end
      if (c_wr_en3) wrs++;
      if (rd_en3 && acc_en3) overlap++;
      cyc++;
      tick();
    end
    tests++;
    if (cyc !== 126) begin
      fails++;
      $display("FAIL n3_busy_len: got %0d expected 126", cyc);
    end
    tests++;
    if (rds !== 27 || accs !== 27 || wrs !== 9) begin
      fails++;
      $display("FAIL n3_strobe_counts: got rd=%0d acc=%0d wr=%0d expected 27 27 9", rds, accs, wrs);
    end
    tests++;
    if (bad_gap !== 0) begin
      fails++;
      $display("FAIL n3_wait_gap: got %0d bad read-to-mac gaps expected 0", bad_gap);
    end
    tests++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL n3_rd_acc_overlap: got %0d expected 0", overlap);
    end
    tests++;
    if (done3 !== 1'b1) begin
      fails++;
      $display("FAIL n3_done: got %b expected 1", done3);
    end
    tick();
  endtask

  task automatic test_n0;
    run1("n0", 4'd0, 16'h1234, 16'h2345, 16'h3456, 0);
  endtask

  task automatic test_start_held;
    int cnt;
    push_run(4'd1, 16'h0040, 16'h0050, 16'h0060);
    push_run(4'd1, 16'h0040, 16'h0050, 16'h0060);
    n = 4'd1; base_a = 16'h0040; base_b = 16'h0050; base_c = 16'h0060;
    start1 = 1'b1;
    tick();
    cnt = 0;
    while (busy1 && cnt < 100) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt !== 4 || done1 !== 1'b1) begin
      fails++;
      $display("FAIL held_run1: got busy_len=%0d done=%b expected 4 1", cnt, done1);
    end
    tick();
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL held_idle_gap: got busy=%b done=%b expected 0 0", busy1, done1);
    end
    tick();
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL held_restart: got busy=%b expected 1", busy1);
    end
    start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 100) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt !== 4 || done1 !== 1'b1) begin
      fails++;
      $display("FAIL held_run2: got busy_len=%0d done=%b expected 4 1", cnt, done1);
    end
    tick();
    tests++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      fails++;
      $display("FAIL held_sb_drain: got rd_left=%0d wr_left=%0d expected 0 0", exp_rd.size(), exp_wr.size());
    end
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic test_wrap;
    run1("wrap", 4'd2, 16'hFFFF, 16'hFFF0, 16'hFFFE, 24);
  endtask

  task automatic test_back_to_back;
    run1("b2b_n4", 4'd4, 16'h0A00, 16'h0B00, 16'h0C00, 16 * (2 + 4 * 2));
    run1("b2b_n1", 4'd1, 16'h0007, 16'h0009, 16'h000B, 4);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_reset_mid_run();
    test_n2();
    test_n3_lat3();
    test_n0();
    test_start_held();
    test_wrap();
    test_back_to_back();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
